// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file slice.
package wb_regfile_pkg;

  localparam logic [31:0] ZERO_WORD  = 32'h0;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_NUM    = 32;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  typedef logic [31:0]           word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// 32 x 32-bit GPR array: two gated combinational read ports, one write port,
// asynchronous active-low clear. Register 0 is hardwired to zero.
module regfile_2r1w
  import wb_regfile_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  word_t     wdata_i,
  input  logic      re1_i,
  input  reg_addr_t raddr1_i,
  output word_t     rdata1_o,
  input  logic      re2_i,
  input  reg_addr_t raddr2_i,
  output word_t     rdata2_o
);

  word_t regs_q [REG_NUM];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= ZERO_WORD;
      end
    end else if (we_i == WRITE_ENABLE && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = ZERO_WORD;
    if (re1_i == READ_ENABLE && raddr1_i != '0) begin
      rdata1_o = regs_q[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = ZERO_WORD;
    if (re2_i == READ_ENABLE && raddr2_i != '0) begin
      rdata2_o = regs_q[raddr2_i];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: GPRs, HI/LO pair and a retire counter.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       wb_wd,
  input  logic             wb_wreg,
  input  logic [31:0]      wb_wdata,
  input  logic             wb_whilo,
  input  logic [31:0]      wb_hi,
  input  logic [31:0]      wb_lo,
  input  logic             re1,
  input  logic             re2,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [31:0]      rdata1,
  output logic [31:0]      rdata2,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic [CNT_W-1:0] retire_cnt
);

  word_t            rf_rdata1;
  word_t            rf_rdata2;
  word_t            hi_q, hi_d;
  word_t            lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  regfile_2r1w u_gpr (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .we_i     (wb_wreg),
    .waddr_i  (wb_wd),
    .wdata_i  (wb_wdata),
    .re1_i    (re1),
    .raddr1_i (raddr1),
    .rdata1_o (rf_rdata1),
    .re2_i    (re2),
    .raddr2_i (raddr2),
    .rdata2_o (rf_rdata2)
  );

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (wb_whilo == WRITE_ENABLE) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
    // A cycle retiring both a GPR and a HI/LO write counts as one event.
    if (wb_wreg == WRITE_ENABLE || wb_whilo == WRITE_ENABLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= ZERO_WORD;
      lo_q  <= ZERO_WORD;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;

`ifdef WB_REGFILE_BYPASS_EN
  // Forwarding is gated by rst_n so reads stay zero throughout reset.
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    hi_o   = hi_q;
    lo_o   = lo_q;
    if (rst_n && re1 == READ_ENABLE && raddr1 != '0 &&
        wb_wreg == WRITE_ENABLE && wb_wd == raddr1) begin
      rdata1 = wb_wdata;
    end
    if (rst_n && re2 == READ_ENABLE && raddr2 != '0 &&
        wb_wreg == WRITE_ENABLE && wb_wd == raddr2) begin
      rdata2 = wb_wdata;
    end
    if (rst_n && wb_whilo == WRITE_ENABLE) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end
  end
`else
  assign rdata1 = rf_rdata1;
  assign rdata2 = rf_rdata2;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile (CNT_W=4); expectations follow WB_REGFILE_BYPASS_EN.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [31:0] hi_o, lo_o;
  logic [3:0]  retire_cnt;

  wb_regfile #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata),
    .wb_whilo   (wb_whilo),
    .wb_hi      (wb_hi),
    .wb_lo      (wb_lo),
    .re1        (re1),
    .re2        (re2),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          c1;
    logic [31:0] e1;
    bit          c2;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic [3:0]  ecnt;
  } exp_t;

  exp_t exp_q[$];
  int   pending;
  int   n_pass;
  int   n_total;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endfunction

  // Monitor: pops an expectation whenever one is posted and compares DUT outputs.
  initial begin
    exp_t e;
    forever begin
      wait (pending > 0);
      e = exp_q.pop_front();
      if (e.c1) cmp({e.name, ".rdata1"}, rdata1, e.e1);
      if (e.c2) cmp({e.name, ".rdata2"}, rdata2, e.e2);
      cmp({e.name, ".hi_o"}, hi_o, e.ehi);
      cmp({e.name, ".lo_o"}, lo_o, e.elo);
      cmp({e.name, ".retire_cnt"}, {28'h0, retire_cnt}, {28'h0, e.ecnt});
      pending--;
    end
  end

  task automatic expect_now(string nm, bit c1, logic [31:0] e1, bit c2, logic [31:0] e2,
                            logic [31:0] ehi, logic [31:0] elo, logic [3:0] ecnt);
    exp_t e;
    #1;
    e.name = nm; e.c1 = c1; e.e1 = e1; e.c2 = c2; e.e2 = e2;
    e.ehi = ehi; e.elo = elo; e.ecnt = ecnt;
    exp_q.push_back(e);
    pending++;
    #1;
    if (pending != 0) begin
      n_total++;
      $display("FAIL %s: monitor did not consume expectation, pending=%0d, required 0", nm, pending);
      exp_q.delete();
      pending = 0;
    end
  endtask

  task automatic set_wb(logic wreg, logic [4:0] wd, logic [31:0] wdata,
                        logic whilo, logic [31:0] hi, logic [31:0] lo);
    wb_wreg = wreg; wb_wd = wd; wb_wdata = wdata;
    wb_whilo = whilo; wb_hi = hi; wb_lo = lo;
  endtask

  task automatic set_rd(logic r1, logic [4:0] a1, logic r2, logic [4:0] a2);
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  task automatic idle();
    set_wb(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    n_pass = 0; n_total = 0; pending = 0;
    rst_n = 1'b1;
    idle();
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    #1 rst_n = 1'b0;
    set_rd(1'b1, 5'd5, 1'b1, 5'd3);
    expect_now("reset", 1, 32'h0, 1, 32'h0, 32'h0, 32'h0, 4'd0);

    @(negedge clk); rst_n = 1'b1;
    expect_now("post_reset", 1, 32'h0, 1, 32'h0, 32'h0, 32'h0, 4'd0);

    // write then read
    @(negedge clk);
    set_wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0);
    set_rd(1'b1, 5'd5, 1'b0, 5'd0);
    expect_now("wr5_same", 1, BYP ? 32'hDEADBEEF : 32'h0, 0, 32'h0, 32'h0, 32'h0, 4'd0);
    @(negedge clk); idle();
    expect_now("wr5_read", 1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 32'h0, 4'd1);

    // GPR0 protection
    @(negedge clk);
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0);
    set_rd(1'b1, 5'd0, 1'b1, 5'd5);
    expect_now("gpr0_same", 1, 32'h0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 4'd1);
    @(negedge clk); idle();
    expect_now("gpr0_read", 1, 32'h0, 1, 32'hDEADBEEF, 32'h0, 32'h0, 4'd2);

    // same-cycle read of register being written
    @(negedge clk);
    set_wb(1'b1, 5'd3, 32'h11111111, 1'b0, 32'h0, 32'h0);
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    expect_now("r3_pre", 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 4'd2);
    @(negedge clk);
    set_wb(1'b1, 5'd3, 32'h12345678, 1'b0, 32'h0, 32'h0);
    set_rd(1'b1, 5'd3, 1'b1, 5'd3);
    expect_now("r3_same", 1, BYP ? 32'h12345678 : 32'h11111111,
               1, BYP ? 32'h12345678 : 32'h11111111, 32'h0, 32'h0, 4'd3);
    @(negedge clk); idle();
    expect_now("r3_next", 1, 32'h12345678, 1, 32'h12345678, 32'h0, 32'h0, 4'd4);

    @(negedge clk); set_rd(1'b0, 5'd5, 1'b0, 5'd3);
    expect_now("re_off", 1, 32'h0, 1, 32'h0, 32'h0, 32'h0, 4'd4);

    // HI/LO
    @(negedge clk);
    set_wb(1'b0, 5'd0, 32'h0, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A);
    set_rd(1'b1, 5'd5, 1'b0, 5'd0);
    expect_now("hilo_same", 1, 32'hDEADBEEF, 0, 32'h0,
               BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'h5A5A5A5A : 32'h0, 4'd4);
    @(negedge clk); idle();
    expect_now("hilo_after", 1, 32'hDEADBEEF, 0, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'd5);
    @(negedge clk);
    expect_now("hilo_hold", 1, 32'hDEADBEEF, 0, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'd5);

    // GPR and HI/LO in one cycle retire once
    @(negedge clk);
    set_wb(1'b1, 5'd7, 32'h77777777, 1'b1, 32'h00000001, 32'h00000002);
    set_rd(1'b1, 5'd7, 1'b0, 5'd0);
    expect_now("both_same", 1, BYP ? 32'h77777777 : 32'h0, 0, 32'h0,
               BYP ? 32'h1 : 32'hA5A5A5A5, BYP ? 32'h2 : 32'h5A5A5A5A, 4'd5);
    @(negedge clk); idle();
    expect_now("both_after", 1, 32'h77777777, 0, 32'h0, 32'h1, 32'h2, 4'd6);

    // async reset mid-stream with a write in flight
    @(negedge clk);
    set_wb(1'b1, 5'd9, 32'h99999999, 1'b1, 32'h0000000C, 32'h0000000D);
    set_rd(1'b1, 5'd9, 1'b1, 5'd5);
    #1 rst_n = 1'b0;
    expect_now("rst_mid", 1, 32'h0, 1, 32'h0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    expect_now("rst_hold", 1, 32'h0, 1, 32'h0, 32'h0, 32'h0, 4'd0);
    rst_n = 1'b1;
    expect_now("rst_rel_same", 1, BYP ? 32'h99999999 : 32'h0, 1, 32'h0,
               BYP ? 32'hC : 32'h0, BYP ? 32'hD : 32'h0, 4'd0);
    @(negedge clk); idle();
    set_rd(1'b1, 5'd9, 1'b1, 5'd7);
    expect_now("rst_rel_after", 1, 32'h99999999, 1, 32'h0, 32'hC, 32'hD, 4'd1);

    // counter wrap: 15 more write-backs take 1 -> 0
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      set_wb(1'b1, 5'd0, 32'(i), 1'b0, 32'h0, 32'h0);
      set_rd(1'b0, 5'd0, 1'b0, 5'd0);
      expect_now("wrap_step", 0, 32'h0, 0, 32'h0, 32'hC, 32'hD, 4'(i + 1));
    end
    @(negedge clk); idle();
    set_rd(1'b0, 5'd5, 1'b1, 5'd9);
    expect_now("wrap", 1, 32'h0, 1, 32'h99999999, 32'hC, 32'hD, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retire counter.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: wb_wd  input  5  GPR write address from the MEM/WB register.
REQ-005 Port: wb_wreg  input  1  GPR write enable.
REQ-006 Port: wb_wdata  input  32  GPR write data.
REQ-007 Port: wb_whilo  input  1  HI/LO write enable.
REQ-008 Port: wb_hi  input  32  HI write data.
REQ-009 Port: wb_lo  input  32  LO write data.
REQ-010 Port: re1, re2  input  1 each  read enables, ports 1 and 2.
REQ-011 Port: raddr1, raddr2  input  5 each  read addresses.
REQ-012 Port: rdata1, rdata2  output  32 each  combinational read data.
REQ-013 Port: hi_o, lo_o  output  32 each  current HI/LO value.
REQ-014 Port: retire_cnt  output  CNT_W  count of committed write-back events.

Function
REQ-015 The block SHALL hold 32 x 32-bit GPRs, where GPR0 reads as 0 and is never written.
REQ-016 The block SHALL write GPR[wb_wd] with wb_wdata on a rising clk edge when wb_wreg=1 and wb_wd!=0, so the value is visible one cycle later.
REQ-017 The block SHALL write HI and LO together with wb_hi and wb_lo on a rising clk edge when wb_whilo=1; HI and LO keep their value otherwise.
REQ-018 rdataN SHALL be 0 when reN=0 or raddrN=0; otherwise it SHALL be GPR[raddrN], subject to REQ-024.
REQ-019 Both read ports SHALL be fully independent; equal addresses return identical data.
REQ-020 retire_cnt SHALL increment by 1 on each rising edge where wb_wreg=1 or wb_whilo=1, including a GPR0 write; a cycle with both set counts once.
REQ-021 retire_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-022 A wb_wreg=1/wb_wd=0 write SHALL leave all GPRs unchanged.

Reset
REQ-023 When rst_n=0, all GPRs, HI, LO and retire_cnt SHALL clear to 0 immediately (asynchronously) and remain 0 while rst_n=0; writes are ignored. A reset asserted mid-write discards that write; the first write after deassertion takes effect on the first rising edge with rst_n=1.

Configuration
REQ-024 With WB_REGFILE_BYPASS_EN defined, the following SHALL hold:
- rdataN SHALL return wb_wdata when reN=1, raddrN!=0, wb_wreg=1 and wb_wd=raddrN.
- hi_o/lo_o SHALL return wb_hi/wb_lo when wb_whilo=1.
- Both apply in the same cycle, and bypass is suppressed while rst_n=0.
REQ-025 With WB_REGFILE_BYPASS_EN undefined, every read SHALL return stored state only, and the new value SHALL appear one cycle after the write.

Structure
REQ-026 The shared defines file SHALL hold: ZERO_WORD (32'h0), REG_ADDR_W (5), REG_NUM (32) and the enable-level constants; the block SHALL use only these.
REQ-027 The GPR array SHALL be a sub-module regfile_2r1w (2 read ports, 1 write port, asynchronous clear); HI/LO, bypass and the counter SHALL stay in the top module.

Verification
REQ-028 Bench scenario, write then read: wb_wreg=1, wb_wd=5, wb_wdata=32'hDEADBEEF -> next cycle re1=1, raddr1=5 reads DEADBEEF, and retire_cnt=1.
REQ-029 Bench scenario, GPR0 protection: write 32'hFFFFFFFF to reg 0 -> raddr1=0 reads 0, and retire_cnt still increments.
REQ-030 Bench scenario, same-cycle read of register being written (3<-32'h12345678): bypass defined -> rdata2=12345678 that cycle; undefined -> the old value that cycle, then 12345678 next cycle.
REQ-031 Bench scenario, HI/LO: wb_whilo=1, hi=32'hA5A5A5A5, lo=32'h5A5A5A5A -> hi_o/lo_o hold these after the edge, and they persist while wb_whilo=0.
REQ-032 Bench scenario, async reset mid-stream: drop rst_n between edges after several writes -> all reads, hi_o, lo_o and retire_cnt are 0 before the next edge.
REQ-033 Bench scenario, counter wrap: CNT_W=4, 16 write-back cycles -> retire_cnt returns to 0; a read with re1=0, raddr1=5 -> 0.
